// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit down-counter timer with level interrupt.
// Register window BASE_ADDR+0x0..+0xb: CTRL (+0x0), PRESET (+0x4), COUNT (+0x8, read-only).
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count, count_next;
    logic        int_flag, flag_next;
    logic        en_clr;

    logic        hit;
    logic [31:0] offset;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        run;
    logic        auto_reload;

    assign offset      = addr - BASE_ADDR;
    assign sel         = offset[3:2];
    assign hit         = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 32'h0000_000b);
    assign wr_ctrl     = we && hit && (sel == 2'd0);
    assign wr_preset   = we && hit && (sel == 2'd1);
    assign auto_reload = (ctrl_mode == 2'b01);
    // While counting, a CTRL write in this cycle overrides the stored EN so the
    // freeze happens at the write edge itself.
    assign run         = wr_ctrl ? wdata[0] : ctrl_en;

    assign irq = ctrl_im & int_flag;

    // Combinational read mux of the addressed register; misses read zero.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
                2'd1:    rdata = preset;
                2'd2:    rdata = count;
                default: rdata = '0;
            endcase
        end
    end

    // Next-state, next-count and interrupt-flag logic of the timer FSM.
    always_comb begin
        state_next = state;
        count_next = count;
        flag_next  = int_flag;
        en_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_en) state_next = S_LOAD;
            end
            S_LOAD: begin
                count_next = preset;
                state_next = S_CNT;
            end
            S_CNT: begin
                if (!run) begin
                    state_next = S_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    count_next = '0;
                    flag_next  = 1'b1;
                    state_next = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    flag_next  = 1'b0;
                    state_next = S_LOAD;
                end else begin
                    en_clr     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if ((wr_ctrl || wr_preset) && !auto_reload) flag_next = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Counter and interrupt flag registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count    <= '0;
            int_flag <= 1'b0;
        end else begin
            count    <= count_next;
            int_flag <= flag_next;
        end
    end

    // Software-visible CTRL/PRESET registers; a CTRL write beats the one-shot EN clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wdata[0];
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end else if (en_clr) begin
                ctrl_en   <= 1'b0;
            end
            if (wr_preset) preset <= wdata;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer; a reference model predicts
// rdata/irq for each cycle, a monitor compares them on the falling edge.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_7f00;
    localparam logic [31:0] A_CTRL  = 32'h0000_7f00;
    localparam logic [31:0] A_PRE   = 32'h0000_7f04;
    localparam logic [31:0] A_CNT   = 32'h0000_7f08;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic        clk;
    logic        clr_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        irq;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    bit        m_en;
    bit [1:0]  m_mode;
    bit        m_im;
    bit [31:0] m_preset;
    bit [31:0] m_count;
    bit        m_flag;
    int        m_phase;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd11);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (!in_window(a)) return 32'd0;
        idx = int'((a - BASE) / 4);
        if (idx == 0) return {28'd0, m_im, m_mode, m_en};
        if (idx == 1) return m_preset;
        return m_count;
    endfunction

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_im = 0; m_preset = 0;
        m_count = 0; m_flag = 0; m_phase = PH_IDLE;
    endtask

    // One clock edge of the timer as described by the register/FSM rules.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w);
        bit wc, wp, go, oneshot, drop_en;
        int idx;
        int n_phase;
        bit [31:0] n_count;
        bit n_flag;
        idx = in_window(a) ? int'((a - BASE) / 4) : -1;
        wc = w && (idx == 0);
        wp = w && (idx == 1);
        go = wc ? d[0] : m_en;
        oneshot = (m_mode != 2'b01);
        drop_en = 0;
        n_phase = m_phase; n_count = m_count; n_flag = m_flag;
        if (m_phase == PH_IDLE) begin
            if (m_en) n_phase = PH_LOAD;
        end else if (m_phase == PH_LOAD) begin
            n_count = m_preset;
            n_phase = PH_CNT;
        end else if (m_phase == PH_CNT) begin
            if (!go) n_phase = PH_IDLE;
            else if (m_count >= 2) n_count = m_count - 1;
            else begin
                n_count = 0; n_flag = 1; n_phase = PH_INT;
            end
        end else begin
            if (oneshot) begin
                drop_en = 1; n_phase = PH_IDLE;
            end else begin
                n_flag = 0; n_phase = PH_LOAD;
            end
        end
        if ((wc || wp) && oneshot) n_flag = 0;
        if (wc) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
        end else if (drop_en) m_en = 0;
        if (wp) m_preset = d;
        m_phase = n_phase; m_count = n_count; m_flag = n_flag;
    endtask

    task automatic push_exp(input logic [31:0] a, input string tag);
        exp_t e;
        e.rdata = model_read(a);
        e.irq   = m_im & m_flag;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // One bus cycle: drive just after the rising edge, predict, advance the model.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input string tag);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        addr = a; wdata = d; we = w;
        push_exp(a, tag);
        model_step(a, d, w);
    endtask

    task automatic do_reset(input logic [31:0] a, input string tag);
        @(posedge clk);
        #1;
        clr_n = 1'b0;
        addr = a; we = 1'b0; wdata = '0;
        model_reset();
        push_exp(a, tag);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
        cyc(a, d, 1'b1, tag);
    endtask

    task automatic rd(input logic [31:0] a, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(a, 32'd0, 1'b0, tag);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (rdata !== e.rdata || irq !== e.irq) begin
                fails++;
                $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                         e.tag, rdata, irq, e.rdata, e.irq);
            end
        end
    end

    initial begin
        logic [31:0] ra, rdv;
        int sel;
        clr_n = 1'b1; addr = '0; wdata = '0; we = 1'b0;
        model_reset();

        do_reset(A_CTRL, "reset_init");
        rd(A_CTRL, 1, "post_reset_ctrl");

        // Reset while counting
        wr(A_PRE, 32'd10, "t1_preset");
        wr(A_CTRL, 32'h1, "t1_en");
        rd(A_CNT, 9, "t1_count");
        do_reset(A_CNT, "t1_reset");
        rd(A_CTRL, 1, "t1_ctrl0");
        rd(A_PRE, 1, "t1_pre0");
        rd(A_CNT, 1, "t1_cnt0");
        rd(32'h0000_7f0c, 1, "t1_miss0");

        // One-shot with interrupt enabled
        wr(A_PRE, 32'd5, "t2_preset");
        wr(A_CTRL, 32'h9, "t2_ctrl");
        rd(A_CNT, 10, "t2_count");
        rd(A_CTRL, 2, "t2_en_clear");
        wr(A_CTRL, 32'h8, "t2_ack");
        rd(A_CNT, 3, "t2_after_ack");

        // Auto-reload pulses
        wr(A_PRE, 32'd2, "t3_preset");
        wr(A_CTRL, 32'hB, "t3_ctrl");
        rd(A_CNT, 14, "t3_reload");
        wr(A_CTRL, 32'h0, "t3_stop");
        rd(A_CNT, 2, "t3_stopped");

        // Freeze mid-count then re-enable
        wr(A_PRE, 32'd10, "t4_preset");
        wr(A_CTRL, 32'h9, "t4_ctrl");
        rd(A_CNT, 5, "t4_count");
        wr(A_CTRL, 32'h8, "t4_freeze");
        rd(A_CNT, 4, "t4_frozen");
        wr(A_CTRL, 32'h9, "t4_reen");
        rd(A_CNT, 4, "t4_reload");
        wr(A_CTRL, 32'h0, "t4_stop");

        // Masked expiry, then unmask
        wr(A_PRE, 32'd1, "t5_preset");
        wr(A_CTRL, 32'h1, "t5_ctrl");
        rd(A_CNT, 6, "t5_expire");
        wr(A_CTRL, 32'h8, "t5_unmask");
        rd(A_CTRL, 3, "t5_noirq");

        // PRESET = 0 acts as 1
        wr(A_PRE, 32'd0, "t5b_preset0");
        wr(A_CTRL, 32'h9, "t5b_ctrl");
        rd(A_CNT, 6, "t5b_count");
        wr(A_CTRL, 32'h0, "t5b_stop");

        // Out-of-window and read-only accesses
        wr(A_PRE, 32'h55, "t6_preset");
        wr(32'h0000_7f0c, 32'h1234, "t6_miss_wr");
        wr(A_CNT, 32'h1234, "t6_count_wr");
        rd(32'h0000_7f0c, 1, "t6_miss_rd");
        rd(32'h0000_7f05, 1, "t6_unaligned");
        rd(A_CNT, 1, "t6_count");
        rd(32'h0000_7eff, 1, "t6_below");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: ra = A_CNT;
                3:       ra = A_CTRL;
                4:       ra = A_PRE;
                5:       ra = BASE + 32'($urandom_range(0, 11));
                6:       ra = BASE + 32'($urandom_range(12, 40));
                7:       ra = BASE - 32'($urandom_range(1, 8));
                default: ra = A_CNT;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    ra = A_CTRL;
                    rdv = 32'($urandom_range(0, 15)) | ($urandom() & 32'hffff_fff0);
                end else begin
                    ra = A_PRE;
                    rdv = 32'($urandom_range(0, 6));
                end
                wr(ra, rdv, "rand_wr");
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset(ra, "rand_reset");
            end else begin
                cyc(ra, $urandom(), 1'b0, "rand_rd");
            end
        end

        @(posedge clk);
        #1;
        we = 1'b0;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
